muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multiply/divide unit with HI/LO result registers for the pipelined MIPS core's execute stage. It supersedes the fixed-width, fixed-latency HI/LO unit. It adds configurable data width, configurable multiply latency, iterative signed/unsigned division, multiply-accumulate/subtract, and an abort input for exception flushes. The execute stage stalls while `busy` is high and reads `hi`/`lo` directly for MFHI/MFLO.

## Interface
- `WIDTH`, 32, operand and HI/LO register width (≥4, even)
- `MUL_CYCLES`, 5, multiply/MADD/MSUB latency in cycles (≥1)
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request; sampled only when `busy`=0
- `op`  in  4  operation code (see package `muldiv_pkg`)
- `a`  in  WIDTH  operand A (rs value, forwarded)
- `b`  in  WIDTH  operand B (rt value, forwarded)
- `cancel`  in  1  abort in-flight operation (exception flush)
- `busy`  out  1  operation in progress
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- Ops: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO. Any other code with `start` has no effect.
- MULT/MULTU: {hi,lo} = a*b as a 2·WIDTH product, signed or unsigned.
- MADD(U)/MSUB(U): {hi,lo} = {hi,lo} ± a*b. Modulo 2^(2·WIDTH). {hi,lo} is sampled at start.
- DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend.
- Divide by zero: lo = all ones, hi = a. Applies to both signed and unsigned.
- Signed overflow (a = most-negative, b = −1): lo = a, hi = 0.
- MTHI/MTLO: hi (resp. lo) = a at the accepting edge. `busy` does not assert.
- Division uses a restoring radix-2 iterative divider. Operands are converted to magnitudes at start, with sign fixup in the final cycle.
- Multiply uses a single-cycle product that passes through a delay counter before commit. No internal multiplier pipelining is required.
- FSM states:
  - IDLE → MUL on accepted multiply-class op.
  - IDLE → DIV on accepted DIV/DIVU.
  - MUL → IDLE when the counter reaches MUL_CYCLES; results commit.
  - DIV → IDLE after WIDTH iteration cycles plus 1 fixup cycle; results commit.
- `start` while `busy`=1 is ignored. The pipeline guarantees stall, and the unit must not latch op or operands.

## Timing
- Reset: hi=0, lo=0, busy=0, FSM=IDLE, counters=0. Reset mid-operation discards the operation.
- Accept at edge k (start=1, busy=0, multi-cycle op):
  - `busy`=1 from edge k through edge k+L−1, then 0 after edge k+L.
  - hi/lo show new values after edge k+L.
  - L = MUL_CYCLES for the multiply class; L = WIDTH+1 for divide.
- Back-to-back: a new start may be accepted at edge k+L, the same edge `busy` falls.
- hi/lo hold pre-operation values throughout busy. MFHI issued during busy is stalled upstream.
- `cancel`=1 at any edge while busy: FSM → IDLE, busy=0 after that edge, hi/lo unchanged.
- `cancel` with `start` in IDLE: request is dropped. This includes MTHI/MTLO.
- `cancel` on the commit edge (k+L): cancel wins and hi/lo are not written.
- `reset` overrides `cancel` and `start`.

## Structure
- `muldiv_pkg`: op encoding localparams (MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MADDU=5, MSUB=6, MSUBU=7, MTHI=8, MTLO=9) and FSM state encoding (IDLE, MUL, DIV).
- One sub-module, `muldiv_divider`: unsigned iterative restoring divider (WIDTH parameter, start/done, quotient/remainder). The top-level unit handles signs, zero-divisor and overflow cases.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 → after 5 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA. Busy high exactly 5 cycles. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2 → after 33 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. MTHI a=0x1234 → hi=0x1234 next edge, busy stays 0.
- Preload hi=0, lo=0xFFFFFFFF via MTLO, then MADDU a=1, b=1 → hi=1, lo=0. MSUB a=1, b=1 → hi=0, lo=0xFFFFFFFF.
- Start DIV, assert cancel at cycle 10 → busy=0 next edge, hi/lo unchanged. Start with different operands during busy → ignored, result matches the first op.
- Reset asserted mid-MULT → hi=lo=0, busy=0 after the edge. Parameter sweep WIDTH=8, MUL_CYCLES=1: DIVU 200/7 → lo=28, hi=4 after 9 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and op-class helpers for the
// multiply/divide unit.
package muldiv_pkg;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MADD  = 4'd4;
   localparam logic [3:0] OP_MADDU = 4'd5;
   localparam logic [3:0] OP_MSUB  = 4'd6;
   localparam logic [3:0] OP_MSUBU = 4'd7;
   localparam logic [3:0] OP_MTHI  = 4'd8;
   localparam logic [3:0] OP_MTLO  = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV
   } state_t;

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
             (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

   function automatic logic is_acc_op(input logic [3:0] op);
      return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic is_sub_op(input logic [3:0] op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, WIDTH cycles
// after the load edge, with a one-cycle done pulse once the result is stable.
module muldiv_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic             running;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // The quotient register doubles as the dividend shift register.
   assign shifted = {remainder, quotient[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvsr};

   always_ff @(posedge clk) begin
      if (reset) begin
         running   <= 1'b0;
         done      <= 1'b0;
         count     <= '0;
         dvsr      <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            running   <= 1'b1;
            count     <= '0;
            dvsr      <= divisor;
            quotient  <= dividend;
            remainder <= '0;
         end else if (abort) begin
            running <= 1'b0;
         end else if (running) begin
            if (diff[WIDTH]) begin
               remainder <= shifted[WIDTH-1:0];
               quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end else begin
               remainder <= diff[WIDTH-1:0];
               quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end
            if (count == CW'(WIDTH - 1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end else begin
               count <= count + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the execute stage: delayed single-cycle
// multiply (with MADD/MSUB), iterative signed/unsigned divide, MTHI/MTLO.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned MCW = $clog2(MUL_CYCLES + 1);

   state_t             state;
   logic [MCW-1:0]     mul_cnt;
   logic [2*WIDTH-1:0] mul_res;
   logic               div_neg_q;
   logic               div_neg_r;
   logic               div_zero;
   logic               div_ovf;
   logic [WIDTH-1:0]   div_a;

   logic               commit;
   logic               accept;
   logic [WIDTH-1:0]   cm_hi;
   logic [WIDTH-1:0]   cm_lo;
   logic [WIDTH-1:0]   cur_hi;
   logic [WIDTH-1:0]   cur_lo;

   logic               sgn;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mul_next;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic               dv_start;
   logic               dv_done;
   logic [WIDTH-1:0]   dv_quot;
   logic [WIDTH-1:0]   dv_rem;

   muldiv_divider #(.WIDTH(WIDTH)) u_divider (
      .clk       (clk),
      .reset     (reset),
      .start     (dv_start),
      .abort     (cancel),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .done      (dv_done),
      .quotient  (dv_quot),
      .remainder (dv_rem)
   );

   assign commit = !cancel &&
                   (((state == ST_MUL) && (mul_cnt == MCW'(MUL_CYCLES))) ||
                    ((state == ST_DIV) && dv_done));

   // A new request is taken on the commit edge as well as in IDLE, so
   // back-to-back ops need no bubble; accumulate ops then see the committed value.
   assign accept = start && !cancel && ((state == ST_IDLE) || commit);

   always_comb begin
      cm_hi = hi;
      cm_lo = lo;
      if (state == ST_MUL) begin
         cm_hi = mul_res[2*WIDTH-1:WIDTH];
         cm_lo = mul_res[WIDTH-1:0];
      end else if (state == ST_DIV) begin
         if (div_zero) begin
            cm_hi = div_a;
            cm_lo = '1;
         end else if (div_ovf) begin
            cm_hi = '0;
            cm_lo = div_a;
         end else begin
            cm_lo = div_neg_q ? -dv_quot : dv_quot;
            cm_hi = div_neg_r ? -dv_rem  : dv_rem;
         end
      end
   end

   assign cur_hi = commit ? cm_hi : hi;
   assign cur_lo = commit ? cm_lo : lo;

   assign sgn   = is_signed_op(op);
   assign ext_a = {{WIDTH{sgn & a[WIDTH-1]}}, a};
   assign ext_b = {{WIDTH{sgn & b[WIDTH-1]}}, b};
   assign prod  = ext_a * ext_b;
   assign acc   = {cur_hi, cur_lo};

   always_comb begin
      mul_next = prod;
      if (is_acc_op(op)) begin
         mul_next = is_sub_op(op) ? (acc - prod) : (acc + prod);
      end
   end

   assign a_neg    = sgn & a[WIDTH-1];
   assign b_neg    = sgn & b[WIDTH-1];
   assign a_mag    = a_neg ? -a : a;
   assign b_mag    = b_neg ? -b : b;
   assign dv_start = accept && is_div_op(op);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         mul_cnt   <= '0;
         mul_res   <= '0;
         div_neg_q <= 1'b0;
         div_neg_r <= 1'b0;
         div_zero  <= 1'b0;
         div_ovf   <= 1'b0;
         div_a     <= '0;
      end else begin
         if (cancel && (state != ST_IDLE)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else if (commit) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            hi    <= cm_hi;
            lo    <= cm_lo;
         end else if (state == ST_MUL) begin
            mul_cnt <= mul_cnt + MCW'(1);
         end

         if (accept) begin
            if (is_mul_op(op)) begin
               state   <= ST_MUL;
               busy    <= 1'b1;
               mul_cnt <= MCW'(1);
               mul_res <= mul_next;
            end else if (is_div_op(op)) begin
               state     <= ST_DIV;
               busy      <= 1'b1;
               div_neg_q <= a_neg ^ b_neg;
               div_neg_r <= a_neg;
               div_zero  <= (b == '0);
               div_ovf   <= sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
               div_a     <= a;
            end else if (op == OP_MTHI) begin
               hi <= a;
            end else if (op == OP_MTLO) begin
               lo <= a;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit/5-cycle instance and an 8-bit/1-cycle
// instance checked against an arithmetic reference model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cancel;

   logic        start0, busy0;
   logic [3:0]  op0;
   logic [31:0] a0, b0, hi0, lo0;

   logic        start1, busy1;
   logic [3:0]  op1;
   logic [7:0]  a1, b1, hi1, lo1;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi [2];
   logic [31:0] m_lo [2];

   muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .op(op0), .a(a0), .b(b0),
      .cancel(cancel), .busy(busy0), .hi(hi0), .lo(lo0)
   );

   muldiv_unit #(.WIDTH(8), .MUL_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
      .cancel(cancel), .busy(busy1), .hi(hi1), .lo(lo1)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic op_is_mul(input logic [3:0] o);
      return o inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   endfunction

   function automatic logic op_is_div(input logic [3:0] o);
      return o inside {OP_DIV, OP_DIVU};
   endfunction

   // Returns {hi, lo} after applying op to the given state, w-bit registers.
   function automatic logic [63:0] ref_result(input int w, input logic [3:0] o,
                                              input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] hi_in, input logic [31:0] lo_in);
      logic [63:0] mask;
      logic [63:0] mask2;
      longint      sx, sy, q, rm;
      logic [63:0] ux, uy, acc, p, r;
      logic        signed_op;
      mask      = (w == 32) ? 64'hFFFF_FFFF : (64'd1 << w) - 64'd1;
      mask2     = (w == 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
      sx        = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
      sy        = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
      ux        = 64'(x);
      uy        = 64'(y);
      acc       = ((64'(hi_in) << w) | 64'(lo_in)) & mask2;
      signed_op = o inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
      p         = signed_op ? 64'(sx * sy) : ux * uy;
      r         = acc;
      case (o)
         OP_MULT, OP_MULTU: r = p;
         OP_MADD, OP_MADDU: r = acc + p;
         OP_MSUB, OP_MSUBU: r = acc - p;
         OP_DIV, OP_DIVU: begin
            if (y == 32'd0) return {x, mask[31:0]};
            if (signed_op) begin
               q  = sx / sy;
               rm = sx % sy;
               return {32'(rm) & mask[31:0], 32'(q) & mask[31:0]};
            end
            return {32'(ux % uy), 32'(ux / uy)};
         end
         OP_MTHI: return {x, lo_in};
         OP_MTLO: return {hi_in, x};
         default: return {hi_in, lo_in};
      endcase
      r = r & mask2;
      return {32'(r >> w) & mask[31:0], 32'(r) & mask[31:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [3:0] o,
                        input logic [31:0] x, input logic [31:0] y);
      if (sel == 0) begin
         start0 = st; op0 = o; a0 = x; b0 = y;
      end else begin
         start1 = st; op1 = o; a1 = x[7:0]; b1 = y[7:0];
      end
   endtask

   function automatic logic [31:0] get_busy(input int sel);
      return (sel == 0) ? 32'(busy0) : 32'(busy1);
   endfunction

   function automatic logic [31:0] get_hi(input int sel);
      return (sel == 0) ? hi0 : {24'd0, hi1};
   endfunction

   function automatic logic [31:0] get_lo(input int sel);
      return (sel == 0) ? lo0 : {24'd0, lo1};
   endfunction

   // Issue one op at a negedge; follows it to completion checking busy and hold.
   task automatic run_op(input int sel, input logic [3:0] o, input logic [31:0] xi,
                         input logic [31:0] yi, input bit junk, input bit chain,
                         input logic [31:0] chain_val);
      int          w;
      int          lat;
      logic [31:0] x, y, exp_hi, exp_lo;
      logic [63:0] r;
      w = (sel == 0) ? 32 : 8;
      x = (sel == 0) ? xi : (xi & 32'hFF);
      y = (sel == 0) ? yi : (yi & 32'hFF);
      r = ref_result(w, o, x, y, m_hi[sel], m_lo[sel]);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      drive(sel, 1'b1, o, x, y);
      @(negedge clk);
      if (op_is_mul(o) || op_is_div(o)) begin
         lat = op_is_div(o) ? w + 1 : ((sel == 0) ? 5 : 1);
         if (junk) drive(sel, 1'b1, OP_MTHI, ~x, ~y);
         else      drive(sel, 1'b0, o, x, y);
         for (int i = 0; i < lat; i++) begin
            check("busy_during_op", get_busy(sel), 32'd1);
            check("hi_hold", get_hi(sel), m_hi[sel]);
            check("lo_hold", get_lo(sel), m_lo[sel]);
            if (i == lat - 1) begin
               if (chain) drive(sel, 1'b1, OP_MTLO, chain_val, 32'd0);
               else       drive(sel, 1'b0, o, x, y);
            end
            @(negedge clk);
         end
         if (chain) begin
            exp_lo = chain_val;
            drive(sel, 1'b0, o, x, y);
         end
      end else begin
         drive(sel, 1'b0, o, x, y);
      end
      check("busy_after", get_busy(sel), 32'd0);
      check("hi_result", get_hi(sel), exp_hi);
      check("lo_result", get_lo(sel), exp_lo);
      m_hi[sel] = exp_hi;
      m_lo[sel] = exp_lo;
   endtask

   // Start an op, then raise cancel so it is sampled 'at' edges after acceptance.
   task automatic cancel_op(input int sel, input logic [3:0] o, input logic [31:0] x,
                            input logic [31:0] y, input int at);
      drive(sel, 1'b1, o, x, y);
      @(negedge clk);
      drive(sel, 1'b0, o, x, y);
      for (int i = 1; i < at; i++) begin
         check("busy_before_cancel", get_busy(sel), 32'd1);
         @(negedge clk);
      end
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("busy_after_cancel", get_busy(sel), 32'd0);
      check("hi_after_cancel", get_hi(sel), m_hi[sel]);
      check("lo_after_cancel", get_lo(sel), m_lo[sel]);
   endtask

   task automatic idle_cancel(input int sel, input logic [3:0] o, input logic [31:0] x);
      cancel = 1'b1;
      drive(sel, 1'b1, o, x, x);
      @(negedge clk);
      cancel = 1'b0;
      drive(sel, 1'b0, o, x, x);
      check("idle_cancel_busy", get_busy(sel), 32'd0);
      check("idle_cancel_hi", get_hi(sel), m_hi[sel]);
      check("idle_cancel_lo", get_lo(sel), m_lo[sel]);
   endtask

   task automatic rnd_op(input int sel);
      int          w;
      int          k;
      logic [3:0]  o;
      logic [31:0] x, y;
      w = (sel == 0) ? 32 : 8;
      o = 4'($urandom_range(0, 11));
      x = $urandom;
      y = $urandom;
      k = $urandom_range(0, 7);
      if (k == 0) begin
         y = 32'd0;
      end else if (k == 1) begin
         x = 32'd1 << (w - 1);
         y = (w == 32) ? 32'hFFFF_FFFF : 32'hFF;
      end
      run_op(sel, o, x, y, 1'($urandom_range(0, 1)), 1'b0, 32'd0);
   endtask

   initial begin
      reset  = 1'b1;
      cancel = 1'b0;
      drive(0, 1'b0, OP_MULT, 32'd0, 32'd0);
      drive(1, 1'b0, OP_MULT, 32'd0, 32'd0);
      for (int s = 0; s < 2; s++) begin
         m_hi[s] = 32'd0;
         m_lo[s] = 32'd0;
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         check("reset_busy", get_busy(s), 32'd0);
         check("reset_hi", get_hi(s), 32'd0);
         check("reset_lo", get_lo(s), 32'd0);
      end

      run_op(0, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 32'd0);
      check("plan_mult_hi", hi0, 32'hFFFF_FFFF);
      check("plan_mult_lo", lo0, 32'hFFFF_FFFA);
      run_op(0, OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0);
      check("plan_multu_hi", hi0, 32'h0000_0002);
      check("plan_multu_lo", lo0, 32'hFFFF_FFFA);

      run_op(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'd0);
      check("plan_div_lo", lo0, 32'hFFFF_FFFD);
      check("plan_div_hi", hi0, 32'hFFFF_FFFF);
      run_op(0, OP_DIVU, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0);
      check("plan_divu0_lo", lo0, 32'hFFFF_FFFF);
      check("plan_divu0_hi", hi0, 32'd7);
      run_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
      check("plan_ovf_lo", lo0, 32'h8000_0000);
      check("plan_ovf_hi", hi0, 32'd0);
      run_op(0, OP_MTHI, 32'h1234, 32'd0, 1'b0, 1'b0, 32'd0);
      check("plan_mthi", hi0, 32'h1234);

      run_op(0, OP_MTHI, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      run_op(0, OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 32'd0);
      run_op(0, OP_MADDU, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0);
      check("plan_maddu_hi", hi0, 32'd1);
      check("plan_maddu_lo", lo0, 32'd0);
      run_op(0, OP_MSUB, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0);
      check("plan_msub_hi", hi0, 32'd0);
      check("plan_msub_lo", lo0, 32'hFFFF_FFFF);

      cancel_op(0, OP_DIV, 32'd1000, 32'd3, 10);
      cancel_op(0, OP_MULT, 32'd12345, 32'd678, 5);
      cancel_op(0, OP_DIVU, 32'd99, 32'd5, 33);
      idle_cancel(0, OP_MTHI, 32'hDEAD_BEEF);
      idle_cancel(0, OP_DIV, 32'h55);
      run_op(0, 4'hF, 32'hAAAA, 32'h5555, 1'b0, 1'b0, 32'd0);
      run_op(0, OP_MULT, 32'h0001_0001, 32'h0001_0001, 1'b0, 1'b1, 32'hCAFE_F00D);
      run_op(0, OP_MADD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'd0);

      for (int t = 0; t < 40; t++) rnd_op(0);

      drive(0, 1'b1, OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
      @(negedge clk);
      drive(0, 1'b0, OP_MULT, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_busy", 32'(busy0), 32'd0);
      check("midreset_hi", hi0, 32'd0);
      check("midreset_lo", lo0, 32'd0);
      for (int s = 0; s < 2; s++) begin
         m_hi[s] = 32'd0;
         m_lo[s] = 32'd0;
      end
      run_op(0, OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0);

      run_op(1, OP_DIVU, 32'd200, 32'd7, 1'b1, 1'b0, 32'd0);
      check("w8_divu_lo", 32'(lo1), 32'd28);
      check("w8_divu_hi", 32'(hi1), 32'd4);
      run_op(1, OP_MULT, 32'hFE, 32'd3, 1'b0, 1'b0, 32'd0);
      check("w8_mult_hi", 32'(hi1), 32'hFF);
      check("w8_mult_lo", 32'(lo1), 32'hFA);
      run_op(1, OP_DIV, 32'h80, 32'hFF, 1'b0, 1'b0, 32'd0);
      cancel_op(1, OP_DIV, 32'd100, 32'd9, 9);
      for (int t = 0; t < 30; t++) rnd_op(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
